// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture: assembles two camera bytes per pixel and streams
// 12-bit pixels with a raster write address into a frame buffer.
module ov7670_capture #(
   parameter int unsigned H_ACTIVE = 320,
   parameter int unsigned V_ACTIVE = 240,
   parameter int unsigned DEPTH    = 76800
) (
   input  logic                       pclk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       vsync,
   input  logic                       href,
   input  logic [7:0]                 d,
   output logic [$clog2(DEPTH)-1:0]   wr_addr,
   output logic                       wr_dv,
   output logic [11:0]                wr_data,
   output logic                       frame_done,
   output logic                       overrun
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = $clog2(DEPTH + 1);
   localparam int unsigned COL_W  = $clog2(H_ACTIVE + 1);
   localparam int unsigned LINE_W = $clog2(V_ACTIVE + 1);

   localparam logic [COL_W-1:0]  H_LIM  = COL_W'(H_ACTIVE);
   localparam logic [LINE_W-1:0] V_LIM  = LINE_W'(V_ACTIVE);
   localparam logic [PTR_W-1:0]  H_STEP = PTR_W'(H_ACTIVE);

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                vsync_q;
   logic                href_q;
   logic                phase_q, phase_d;
   logic [3:0]          red_q, red_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic                line_px_q, line_px_d;
   logic [PTR_W-1:0]    base_q, base_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic                wr_dv_q, wr_dv_d;
   logic [11:0]         wr_data_q, wr_data_d;
   logic                frame_done_q, frame_done_d;
   logic                overrun_q, overrun_d;

   logic vs_rise_c, vs_fall_c, href_fall_c;

   assign vs_rise_c   = vsync & ~vsync_q;
   assign vs_fall_c   = ~vsync & vsync_q;
   assign href_fall_c = href_q & ~href;

   // Next-state, pixel assembly and address generation
   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      red_d        = red_q;
      col_d        = col_q;
      line_d       = line_q;
      line_px_d    = line_px_q;
      base_d       = base_q;
      ptr_d        = ptr_q;
      wr_addr_d    = wr_addr_q;
      wr_dv_d      = 1'b0;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      overrun_d    = overrun_q;

      unique case (state_q)
         WAIT_VS: begin
            if (vsync) state_d = ARMED;
         end

         ARMED: begin
            if (vs_fall_c && en) begin
               state_d   = CAPTURE;
               phase_d   = 1'b0;
               col_d     = '0;
               line_d    = '0;
               line_px_d = 1'b0;
               base_d    = '0;
               ptr_d     = '0;
               wr_addr_d = '0;
               overrun_d = 1'b0;
            end
         end

         CAPTURE: begin
            if (vs_rise_c) begin
               // End of frame wins over any pixel completing in the same cycle
               state_d      = ARMED;
               frame_done_d = 1'b1;
               phase_d      = 1'b0;
               col_d        = '0;
               line_d       = '0;
               line_px_d    = 1'b0;
               base_d       = '0;
               ptr_d        = '0;
            end else if (href) begin
               if (!phase_q) begin
                  red_d   = d[3:0];
                  phase_d = 1'b1;
               end else begin
                  phase_d   = 1'b0;
                  line_px_d = 1'b1;
                  if ((col_q < H_LIM) && (line_q < V_LIM)) begin
                     wr_dv_d   = 1'b1;
                     wr_data_d = {red_q, d};
                     wr_addr_d = ADDR_W'(ptr_q);
                     ptr_d     = ptr_q + 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
                  if (col_q < H_LIM) col_d = col_q + 1'b1;
               end
            end else if (href_fall_c) begin
               // Realign to the next row start regardless of how short the line was
               phase_d   = 1'b0;
               col_d     = '0;
               line_px_d = 1'b0;
               if (line_px_q && (line_q < V_LIM)) begin
                  line_d = line_q + 1'b1;
                  base_d = base_q + H_STEP;
                  ptr_d  = base_q + H_STEP;
               end
            end
         end

         default: state_d = WAIT_VS;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q      <= WAIT_VS;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         phase_q      <= 1'b0;
         red_q        <= '0;
         col_q        <= '0;
         line_q       <= '0;
         line_px_q    <= 1'b0;
         base_q       <= '0;
         ptr_q        <= '0;
         wr_addr_q    <= '0;
         wr_dv_q      <= 1'b0;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         vsync_q      <= vsync;
         href_q       <= href;
         phase_q      <= phase_d;
         red_q        <= red_d;
         col_q        <= col_d;
         line_q       <= line_d;
         line_px_q    <= line_px_d;
         base_q       <= base_d;
         ptr_q        <= ptr_d;
         wr_addr_q    <= wr_addr_d;
         wr_dv_q      <= wr_dv_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign wr_addr    = wr_addr_q;
   assign wr_dv      = wr_dv_q;
   assign wr_data    = wr_data_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule
